xillybus_mem_responder: RTL and testbench

User-side responder for the seekable `/dev/xillybus_mem_8` stream. The host seeks, writes and reads a 32-entry × 8-bit register file through the Xillybus core's addressed read/write ports. A second fabric-side port lets local logic read and write the same array. It sits between the `xillybus` instance and application logic, all on `bus_clk`.

---
 rtl/xillybus_mem_pkg.sv | 12 +
 rtl/xillybus_mem_regfile.sv | 44 ++++
 rtl/xillybus_mem_responder.sv | 103 ++++++++++
 tb/tb_xillybus_mem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/xillybus_mem_pkg.sv
// Shared defaults and types for the xillybus_mem_8 responder and its register file.
package xillybus_mem_pkg;

  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 8;
  localparam int DEPTH        = 2 ** ADDR_W;
  localparam int WRCOUNT_ADDR = DEPTH - 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/xillybus_mem_regfile.sv
// Register file shared by the host stream and the fabric port.
// A host write to the same address wins over a fabric write, and the loss is flagged.
module xillybus_mem_regfile
  import xillybus_mem_pkg::*;
#(
  parameter int ADDR_W = xillybus_mem_pkg::ADDR_W,
  parameter int DATA_W = xillybus_mem_pkg::DATA_W
) (
  input  logic              bus_clk,
  input  logic              reset,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              fab_we,
  input  logic [ADDR_W-1:0] fab_addr,
  input  logic [DATA_W-1:0] fab_wdata,
  output logic [DATA_W-1:0] fab_rdata,
  output logic              fab_wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              collide;

  assign collide    = host_we & fab_we & (host_addr == fab_addr);
  assign host_rdata = mem[host_addr];

  // fab_rdata samples the array before this cycle's writes land
  always_ff @(posedge bus_clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      fab_rdata   <= '0;
      fab_wr_drop <= 1'b0;
    end else begin
      fab_rdata   <= mem[fab_addr];
      fab_wr_drop <= collide;
      if (fab_we && !collide) mem[fab_addr] <= fab_wdata;
      if (host_we) mem[host_addr] <= host_wdata;
    end
  end

endmodule

// File: rtl/xillybus_mem_responder.sv
// Seekable /dev/xillybus_mem_8 responder over a 32 x 8 register file with a fabric port.
// Define XILLYBUS_MEM_RESPONDER_WRCOUNT_EN to turn the last entry into a write counter.
module xillybus_mem_responder
  import xillybus_mem_pkg::*;
#(
  parameter int ADDR_W = xillybus_mem_pkg::ADDR_W,
  parameter int DATA_W = xillybus_mem_pkg::DATA_W
) (
  input  logic              bus_clk,
  input  logic              reset,
  input  logic              user_r_mem_8_rden,
  output logic              user_r_mem_8_empty,
  output logic [DATA_W-1:0] user_r_mem_8_data,
  output logic              user_r_mem_8_eof,
  input  logic              user_r_mem_8_open,
  input  logic              user_w_mem_8_wren,
  output logic              user_w_mem_8_full,
  input  logic [DATA_W-1:0] user_w_mem_8_data,
  input  logic              user_w_mem_8_open,
  input  logic [ADDR_W-1:0] user_mem_8_addr,
  input  logic              user_mem_8_addr_update,
  input  logic [ADDR_W-1:0] fab_addr,
  input  logic              fab_wr,
  input  logic [DATA_W-1:0] fab_wdata,
  output logic [DATA_W-1:0] fab_rdata,
  output logic              fab_wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] ptr;
  logic              wr_acc, rd_acc;
  logic              host_we, fab_we;
  logic [DATA_W-1:0] rf_host_rdata, rf_fab_rdata, host_word;
  logic              unused_w_open;

  assign unused_w_open      = user_w_mem_8_open;
  assign user_w_mem_8_full  = reset | user_mem_8_addr_update;
  assign user_r_mem_8_empty = reset | user_mem_8_addr_update | ~user_r_mem_8_open;
  assign user_r_mem_8_eof   = 1'b0;
  assign wr_acc             = user_w_mem_8_wren & ~user_w_mem_8_full;
  assign rd_acc             = user_r_mem_8_rden & ~user_r_mem_8_empty;

`ifdef XILLYBUS_MEM_RESPONDER_WRCOUNT_EN
  logic [DATA_W-1:0] wr_count, fab_count_q;
  logic              ptr_at_cnt, fab_at_cnt_q;

  assign ptr_at_cnt = (ptr == CNT_ADDR);
  assign host_we    = wr_acc & ~ptr_at_cnt;
  assign fab_we     = fab_wr & (fab_addr != CNT_ADDR);
  assign host_word  = ptr_at_cnt ? wr_count : rf_host_rdata;
  assign fab_rdata  = fab_at_cnt_q ? fab_count_q : rf_fab_rdata;

  // Counter snapshot for the fabric port keeps the same read-before-write timing as the array
  always_ff @(posedge bus_clk) begin
    if (reset) begin
      wr_count     <= '0;
      fab_count_q  <= '0;
      fab_at_cnt_q <= 1'b0;
    end else begin
      fab_at_cnt_q <= (fab_addr == CNT_ADDR);
      fab_count_q  <= wr_count;
      if (host_we && wr_count != '1) wr_count <= wr_count + 1'b1;
    end
  end
`else
  assign host_we   = wr_acc;
  assign fab_we    = fab_wr;
  assign host_word = rf_host_rdata;
  assign fab_rdata = rf_fab_rdata;
`endif

  // A simultaneous write and read share one pointer step; the read sees the written value
  always_ff @(posedge bus_clk) begin
    if (reset) begin
      ptr               <= '0;
      user_r_mem_8_data <= '0;
    end else begin
      if (user_mem_8_addr_update) ptr <= user_mem_8_addr;
      else if (wr_acc || rd_acc) ptr <= ptr + 1'b1;
      if (rd_acc) user_r_mem_8_data <= host_we ? user_w_mem_8_data : host_word;
    end
  end

  xillybus_mem_regfile #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_regfile (
    .bus_clk    (bus_clk),
    .reset      (reset),
    .host_we    (host_we),
    .host_addr  (ptr),
    .host_wdata (user_w_mem_8_data),
    .host_rdata (rf_host_rdata),
    .fab_we     (fab_we),
    .fab_addr   (fab_addr),
    .fab_wdata  (fab_wdata),
    .fab_rdata  (rf_fab_rdata),
    .fab_wr_drop(fab_wr_drop)
  );

endmodule

// File: tb/tb_xillybus_mem_responder.sv
// Directed bench for xillybus_mem_responder; entry 31 expectations follow XILLYBUS_MEM_RESPONDER_WRCOUNT_EN.
module tb_xillybus_mem_responder;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic              bus_clk = 1'b0;
  logic              reset = 1'b1;
  logic              user_r_mem_8_rden = 1'b0;
  logic              user_r_mem_8_empty;
  logic [DATA_W-1:0] user_r_mem_8_data;
  logic              user_r_mem_8_eof;
  logic              user_r_mem_8_open = 1'b1;
  logic              user_w_mem_8_wren = 1'b0;
  logic              user_w_mem_8_full;
  logic [DATA_W-1:0] user_w_mem_8_data = '0;
  logic              user_w_mem_8_open = 1'b1;
  logic [ADDR_W-1:0] user_mem_8_addr = '0;
  logic              user_mem_8_addr_update = 1'b0;
  logic [ADDR_W-1:0] fab_addr = '0;
  logic              fab_wr = 1'b0;
  logic [DATA_W-1:0] fab_wdata = '0;
  logic [DATA_W-1:0] fab_rdata;
  logic              fab_wr_drop;

  int n_checks = 0;
  int n_pass = 0;

  always #5 bus_clk = ~bus_clk;

  xillybus_mem_responder dut (
    .bus_clk               (bus_clk),
    .reset                 (reset),
    .user_r_mem_8_rden     (user_r_mem_8_rden),
    .user_r_mem_8_empty    (user_r_mem_8_empty),
    .user_r_mem_8_data     (user_r_mem_8_data),
    .user_r_mem_8_eof      (user_r_mem_8_eof),
    .user_r_mem_8_open     (user_r_mem_8_open),
    .user_w_mem_8_wren     (user_w_mem_8_wren),
    .user_w_mem_8_full     (user_w_mem_8_full),
    .user_w_mem_8_data     (user_w_mem_8_data),
    .user_w_mem_8_open     (user_w_mem_8_open),
    .user_mem_8_addr       (user_mem_8_addr),
    .user_mem_8_addr_update(user_mem_8_addr_update),
    .fab_addr              (fab_addr),
    .fab_wr                (fab_wr),
    .fab_wdata             (fab_wdata),
    .fab_rdata             (fab_rdata),
    .fab_wr_drop           (fab_wr_drop)
  );

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  // One clock with the given host strobes; strobes drop again after the edge
  task automatic applyStimulus(input logic w, input logic [DATA_W-1:0] wd, input logic r,
                               input logic u, input logic [ADDR_W-1:0] a);
    user_w_mem_8_wren      = w;
    user_w_mem_8_data      = wd;
    user_r_mem_8_rden      = r;
    user_mem_8_addr_update = u;
    user_mem_8_addr        = a;
    tick();
    user_w_mem_8_wren      = 1'b0;
    user_r_mem_8_rden      = 1'b0;
    user_mem_8_addr_update = 1'b0;
    fab_wr                 = 1'b0;
  endtask

  task automatic seek(input logic [ADDR_W-1:0] a);
    user_mem_8_addr_update = 1'b1;
    user_mem_8_addr        = a;
    #1;
    checkOutput("seek_full", user_w_mem_8_full, 1'b1);
    checkOutput("seek_empty", user_r_mem_8_empty, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, a);
  endtask

  task automatic host_write(input logic [DATA_W-1:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, '0);
  endtask

  task automatic fab_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp,
                          input string tag);
    fab_addr = a;
    tick();
    checkOutput(tag, fab_rdata, exp);
  endtask

  initial begin
    tick(); tick(); tick();
    checkOutput("rst_full", user_w_mem_8_full, 1'b1);
    checkOutput("rst_empty", user_r_mem_8_empty, 1'b1);
    checkOutput("rst_data", user_r_mem_8_data, 8'h00);
    checkOutput("rst_fab_rdata", fab_rdata, 8'h00);
    checkOutput("rst_drop", fab_wr_drop, 1'b0);
    checkOutput("rst_eof", user_r_mem_8_eof, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_full", user_w_mem_8_full, 1'b0);
    checkOutput("post_rst_empty", user_r_mem_8_empty, 1'b0);

    // Burst write then burst read from the same seek point
    seek(5'd3);
    host_write(8'hA1);
    host_write(8'hB2);
    host_write(8'hC3);
    seek(5'd3);
    user_r_mem_8_rden = 1'b1;
    tick(); checkOutput("burst_rd0", user_r_mem_8_data, 8'hA1);
    tick(); checkOutput("burst_rd1", user_r_mem_8_data, 8'hB2);
    tick(); checkOutput("burst_rd2", user_r_mem_8_data, 8'hC3);
    user_r_mem_8_rden = 1'b0;
    tick(); checkOutput("data_hold", user_r_mem_8_data, 8'hC3);
    seek(5'd10);
    checkOutput("data_hold_seek", user_r_mem_8_data, 8'hC3);

    // Pointer wrap from 31 to 0
    seek(5'd31);
    host_write(8'h11);
    host_write(8'h22);
`ifdef XILLYBUS_MEM_RESPONDER_WRCOUNT_EN
    fab_read(5'd31, 8'd4, "wrap_entry31_count");
`else
    fab_read(5'd31, 8'h11, "wrap_entry31");
`endif
    fab_read(5'd0, 8'h22, "wrap_entry0");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("wrap_read_entry1", user_r_mem_8_data, 8'h00);

    // Host and fabric write to the same address in one cycle
    seek(5'd7);
    fab_addr  = 5'd7;
    fab_wdata = 8'h66;
    fab_wr    = 1'b1;
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, '0);
    checkOutput("collide_drop_hi", fab_wr_drop, 1'b1);
    tick();
    checkOutput("collide_drop_lo", fab_wr_drop, 1'b0);
    fab_read(5'd7, 8'h55, "collide_entry7");

    // Fabric-only writes and read-before-write on the fabric port
    fab_addr  = 5'd20;
    fab_wdata = 8'h77;
    fab_wr    = 1'b1;
    tick();
    fab_wr = 1'b0;
    checkOutput("fab_only_drop", fab_wr_drop, 1'b0);
    fab_wdata = 8'h88;
    fab_wr    = 1'b1;
    tick();
    fab_wr = 1'b0;
    checkOutput("fab_rbw_old", fab_rdata, 8'h77);
    tick();
    checkOutput("fab_rbw_new", fab_rdata, 8'h88);

    // Write during the seek cycle is dropped
    user_mem_8_addr_update = 1'b1;
    user_mem_8_addr        = 5'd12;
    user_w_mem_8_wren      = 1'b1;
    user_w_mem_8_data      = 8'h99;
    #1;
    checkOutput("seek_wr_full", user_w_mem_8_full, 1'b1);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1, 5'd12);
    fab_read(5'd12, 8'h00, "seek_wr_dropped");
    host_write(8'hAB);
    fab_read(5'd12, 8'hAB, "seek_wr_then_12");
    fab_read(5'd13, 8'h00, "seek_wr_then_13");

    // Simultaneous write and read: write-through and a single pointer step
    seek(5'd14);
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, '0);
    checkOutput("wt_data", user_r_mem_8_data, 8'h5A);
    host_write(8'h3C);
    fab_read(5'd15, 8'h3C, "wt_entry15");
    fab_read(5'd14, 8'h5A, "wt_entry14");
    fab_addr  = 5'd16;
    fab_wdata = 8'hE7;
    fab_wr    = 1'b1;
    tick();
    fab_wr = 1'b0;

    // Read side closed: rden ignored, pointer unchanged
    user_r_mem_8_open = 1'b0;
    #1;
    checkOutput("closed_empty", user_r_mem_8_empty, 1'b1);
    checkOutput("closed_full", user_w_mem_8_full, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("closed_data_hold", user_r_mem_8_data, 8'h5A);
    user_r_mem_8_open = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("reopen_read16", user_r_mem_8_data, 8'hE7);

    // Reset in the middle of a write burst
    seek(5'd0);
    host_write(8'h01);
    reset             = 1'b1;
    user_w_mem_8_wren = 1'b1;
    user_w_mem_8_data = 8'h02;
    #1;
    checkOutput("midrst_full", user_w_mem_8_full, 1'b1);
    checkOutput("midrst_empty", user_r_mem_8_empty, 1'b1);
    tick();
    reset             = 1'b0;
    user_w_mem_8_wren = 1'b0;
    #1;
    checkOutput("midrst_full_after", user_w_mem_8_full, 1'b0);
    checkOutput("midrst_data", user_r_mem_8_data, 8'h00);
    fab_read(5'd0, 8'h00, "midrst_entry0");
    fab_read(5'd3, 8'h00, "midrst_entry3");
    fab_read(5'd7, 8'h00, "midrst_entry7");
    host_write(8'h42);
    fab_read(5'd0, 8'h42, "midrst_ptr0");
    fab_read(5'd1, 8'h00, "midrst_entry1");
    checkOutput("eof_low", user_r_mem_8_eof, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
